// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_arbiter
// Desc   : Packet-granular round-robin sharing of one UART TX among N_REQ
//          byte sources; optional stalled-owner timeout via UART_TX_ARB_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               new_tx_data,
  input  logic               tx_busy
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic               timeout_evt
`endif
);

  localparam int IW  = $clog2(N_REQ);
  localparam int IW1 = IW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  state_t           state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             new_tx_data_q, new_tx_data_d;
  logic             last_q, last_d;

  logic             scan_found;
  logic [IW-1:0]    scan_idx;
  logic [IW1-1:0]   scan_pos;
  logic             accept;
  logic             expire;
  logic [IW-1:0]    owner_next;

  // Round-robin scan starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    scan_pos   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_pos = {1'b0, ptr_q} + IW1'(k);
      if (scan_pos >= IW1'(N_REQ)) begin
        scan_pos = scan_pos - IW1'(N_REQ);
      end
      if (!scan_found && req_valid[scan_pos[IW-1:0]]) begin
        scan_found = 1'b1;
        scan_idx   = scan_pos[IW-1:0];
      end
    end
  end

  assign accept     = (state_q == ST_SEND) && req_valid[owner_q] && !tx_busy;
  assign owner_next = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[owner_q] = 1'b1;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_evt_q, timeout_evt_d;
  logic          stalled;

  assign stalled = (state_q == ST_SEND) && !req_valid[owner_q];
  assign expire  = stalled && (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Counts only cycles where the owner has nothing to offer; tx_busy stalls do not age it.
  always_comb begin
    to_cnt_d      = to_cnt_q;
    timeout_evt_d = 1'b0;
    if (accept || expire) begin
      to_cnt_d = '0;
    end else if (stalled) begin
      to_cnt_d = to_cnt_q + CW'(1);
    end
    if (expire) begin
      timeout_evt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q      <= '0;
      timeout_evt_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_evt_q <= timeout_evt_d;
    end
  end

  assign timeout_evt = timeout_evt_q;
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    tx_data_d     = tx_data_q;
    new_tx_data_d = 1'b0;
    last_d        = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (scan_found) begin
          owner_d = scan_idx;
          grant_d = N_REQ'(1) << scan_idx;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept) begin
          tx_data_d     = req_data[{owner_q, 3'b000} +: 8];
          new_tx_data_d = 1'b1;
          last_d        = req_last[owner_q];
          state_d       = ST_GAP;
        end else if (expire) begin
          grant_d = '0;
          ptr_d   = owner_next;
          state_d = ST_IDLE;
        end
      end
      // Holdoff cycle gives the serial TX time to raise tx_busy after a strobe.
      ST_GAP: begin
        if (last_q) begin
          grant_d = '0;
          ptr_d   = owner_next;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      ptr_q         <= '0;
      grant_q       <= '0;
      tx_data_q     <= 8'h00;
      new_tx_data_q <= 1'b0;
      last_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      tx_data_q     <= tx_data_d;
      new_tx_data_q <= new_tx_data_d;
      last_q        <= last_d;
    end
  end

  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a packet-level model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           new_tx_data;
  logic           tx_busy = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic           timeout_evt;
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_data(tx_data),
    .new_tx_data(new_tx_data), .tx_busy(tx_busy)
`ifdef UART_TX_ARB_TIMEOUT_EN
    , .timeout_evt(timeout_evt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level reference: who owns the TX, whether a holdoff cycle is pending, what was last sent.
  int         m_owner, m_ptr, m_stall;
  bit         m_gap, m_last, m_strobe, m_evt;
  logic [7:0] m_data;

  function automatic void model_reset();
    m_owner = -1; m_ptr = 0; m_stall = 0;
    m_gap = 0; m_last = 0; m_strobe = 0; m_evt = 0; m_data = 8'h00;
  endfunction

  int         cyc = 0;
  int         ready_cnt = 0;
  logic [N-1:0] cons_seen = '0;
  logic [N-1:0] prev_grant = '0;
  logic [7:0] strobe_log[$];
  int         strobe_cyc[$];
  int         grant_log[$];
  int         evt_cyc[$];

  always @(negedge clk) begin
    logic [N-1:0] exp_grant, exp_ready;
    cyc++;
    if (!rst_n) model_reset();
    exp_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    exp_ready = '0;
    if (m_owner >= 0 && !m_gap && req_valid[m_owner] && !tx_busy) exp_ready[m_owner] = 1'b1;
    chk("grant", 32'(grant), 32'(exp_grant));
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("new_tx_data", 32'(new_tx_data), 32'(m_strobe));
    chk("tx_data", 32'(tx_data), 32'(m_data));
`ifdef UART_TX_ARB_TIMEOUT_EN
    chk("timeout_evt", 32'(timeout_evt), 32'(m_evt));
    if (timeout_evt) evt_cyc.push_back(cyc);
`endif
    if (new_tx_data) begin strobe_log.push_back(tx_data); strobe_cyc.push_back(cyc); end
    if (grant != prev_grant && grant != '0) begin
      for (int i = 0; i < N; i++) if (grant[i]) grant_log.push_back(i);
    end
    if (req_ready != '0) ready_cnt++;
    prev_grant = grant;
    cons_seen  = req_ready;

    if (rst_n) begin
      m_strobe = 0;
      m_evt    = 0;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++)
          if (m_owner < 0 && req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end else if (m_gap) begin
        m_gap = 0;
        if (m_last) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
      end else if (req_valid[m_owner] && !tx_busy) begin
        m_data = req_data[8*m_owner +: 8];
        m_last = req_last[m_owner];
        m_strobe = 1; m_gap = 1; m_stall = 0;
      end else if (!req_valid[m_owner]) begin
`ifdef UART_TX_ARB_TIMEOUT_EN
        if (m_stall == TO - 1) begin
          m_evt = 1; m_stall = 0; m_ptr = (m_owner + 1) % N; m_owner = -1;
        end else begin
          m_stall++;
        end
`endif
      end
    end
  end

  // Byte sources: each requester presents the head of its queue while enabled.
  logic [8:0]   srcq [N][$];
  logic [N-1:0] en = '1;

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = en[i] && (srcq[i].size() > 0);
      if (srcq[i].size() > 0) begin
        req_data[8*i +: 8] = srcq[i][0][7:0];
        req_last[i]        = srcq[i][0][8];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++)
      if (cons_seen[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    apply();
  endtask

  task automatic clear_logs();
    strobe_log.delete(); strobe_cyc.delete(); grant_log.delete(); evt_cyc.delete();
    ready_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    en = '1; tx_busy = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    clear_logs();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic drain(input string name, input int max);
    int n = 0;
    while (n < max && !(all_empty() && grant == '0 && !new_tx_data)) begin tick(); n++; end
    chk(name, 32'(n < max), 32'd1);
  endtask

  task automatic wait_grant(input logic [N-1:0] g, input int max);
    int n = 0;
    while (n < max && grant != g) begin tick(); n++; end
    chk("wait_grant", 32'(grant), 32'(g));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    // Reset held with every requester valid.
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) srcq[i].push_back({1'b1, 8'(8'hA0 + i)});
    apply();
    tick(); tick(); tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_strobe", 32'(new_tx_data), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    rst_n = 1'b1;
    tick(); tick();
    chk("rst_release_grant", 32'(grant), 32'b0001);
    drain("drain_reset", 100);

    // Single two-byte packet "hi".
    do_reset();
    srcq[0].push_back({1'b0, 8'h68});
    srcq[0].push_back({1'b1, 8'h69});
    apply();
    drain("drain_hi", 50);
    chk("hi_count", 32'(strobe_log.size()), 32'd2);
    chk("hi_byte0", 32'(strobe_log[0]), 32'h68);
    chk("hi_byte1", 32'(strobe_log[1]), 32'h69);
    chk("hi_spacing", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd2);
    chk("hi_grant_end", 32'(grant), 32'h0);

    // Round robin with wrap back to requester 0.
    do_reset();
    for (int i = 0; i < N; i++) srcq[i].push_back({1'b1, 8'(8'h10 + i)});
    srcq[0].push_back({1'b1, 8'h20});
    apply();
    drain("drain_rr", 100);
    chk("rr_count", 32'(grant_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("rr_order", 32'(grant_log[i]), 32'(i % 4));
    chk("rr_last_byte", 32'(strobe_log[4]), 32'h20);

    // Backpressure for 20 cycles.
    do_reset();
    srcq[2].push_back({1'b0, 8'hA5});
    srcq[2].push_back({1'b1, 8'h5A});
    tx_busy = 1'b1;
    apply();
    repeat (20) tick();
    chk("bp_no_strobe", 32'(strobe_log.size()), 32'd0);
    chk("bp_no_ready", 32'(ready_cnt), 32'd0);
    chk("bp_grant", 32'(grant), 32'b0100);
    tx_busy = 1'b0;
    tick();
    chk("bp_release_strobe", 32'(new_tx_data), 32'd1);
    chk("bp_release_data", 32'(tx_data), 32'hA5);
    drain("drain_bp", 50);

    // Packet lock, next grant to req2.
    do_reset();
    srcq[1].push_back({1'b0, 8'h31});
    srcq[1].push_back({1'b0, 8'h32});
    srcq[1].push_back({1'b1, 8'h33});
    apply();
    wait_grant(4'b0010, 5);
    srcq[0].push_back({1'b1, 8'h40});
    srcq[2].push_back({1'b1, 8'h42});
    apply();
    drain("drain_lock", 100);
    chk("lock_n", 32'(grant_log.size()), 32'd3);
    chk("lock_g0", 32'(grant_log[0]), 32'd1);
    chk("lock_g1", 32'(grant_log[1]), 32'd2);
    chk("lock_g2", 32'(grant_log[2]), 32'd0);
    chk("lock_b2", 32'(strobe_log[2]), 32'h33);

    // Packet lock, only req0 waiting.
    do_reset();
    srcq[1].push_back({1'b0, 8'h31});
    srcq[1].push_back({1'b1, 8'h33});
    apply();
    wait_grant(4'b0010, 5);
    srcq[0].push_back({1'b1, 8'h40});
    apply();
    drain("drain_lock2", 100);
    chk("lock2_g1", 32'(grant_log[1]), 32'd0);

    // Owner stalls mid-packet.
    do_reset();
    srcq[3].push_back({1'b0, 8'h77});
    apply();
    wait_grant(4'b1000, 5);
    srcq[0].push_back({1'b1, 8'h50});
    apply();
`ifdef UART_TX_ARB_TIMEOUT_EN
    begin
      int n = 0;
      while (n < 40 && evt_cyc.size() == 0) begin tick(); n++; end
    end
    drain("drain_timeout", 50);
    chk("to_evt_count", 32'(evt_cyc.size()), 32'd1);
    chk("to_evt_delay", 32'(evt_cyc[0] - strobe_cyc[0]), 32'd9);
    chk("to_next_owner", 32'(grant_log[1]), 32'd0);
    chk("to_next_byte", 32'(strobe_log[1]), 32'h50);
`else
    repeat (40) tick();
    chk("hold_grant", 32'(grant), 32'b1000);
    chk("hold_strobes", 32'(strobe_log.size()), 32'd1);
`endif

    // Randomized traffic with a mid-run reset.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() < 3 && $urandom_range(0, 3) == 0) begin
          int len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            srcq[i].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255))});
        end
        en[i] = ($urandom_range(0, 9) != 0);
      end
      tx_busy = ($urandom_range(0, 2) == 0);
      rst_n   = !(c >= 2000 && c < 2002);
      apply();
      tick();
    end
    rst_n = 1'b1; en = '1; tx_busy = 1'b0;
    apply();
    drain("drain_random", 2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
